// File: rtl/itcm_fetch_responder_pkg.sv
// Shared constants for the ITCM fetch responder.
// Default geometry and the instruction substituted for faulting fetches.
package itcm_fetch_responder_pkg;

  localparam int ITCM_DEPTH = 1024;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/itcm_fetch_responder_if.sv
// Fetch request/response, flush and program-load signals.
// master = IF stage / loader, slave = the ITCM responder.
interface itcm_fetch_responder_if
  import itcm_fetch_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_insn;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  modport master (
    output req_valid, req_addr, flush,
    output rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid,
    input  rsp_insn, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush,
    input  rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid,
    output rsp_insn, rsp_addr, rsp_err
  );

endinterface

// File: rtl/itcm_fetch_responder_fifo.sv
// Two-entry response FIFO with registered head.
// flush empties it; entry contents are left in place.
module itcm_resp_fifo #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] ent [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent[0] <= '0;
      ent[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        ent[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign dout  = ent[rd_ptr];
  assign full  = cnt == 2'd2;
  assign empty = cnt == 2'd0;

endmodule

// File: rtl/itcm_fetch_responder.sv
// ITCM fetch responder: single-cycle RAM read stage s1
// feeding a 2-entry response FIFO, with flush and boot load port.
module itcm_fetch_responder
  import itcm_fetch_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = ITCM_DEPTH,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input logic clk,
  input logic reset,
  itcm_fetch_responder_if.slave bus
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int FW = 1 + ADDR_W + DATA_W;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rd_data;
  logic              s1_valid;
  logic              s1_err;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_insn;
  logic              req_err;
  logic              accept;
  logic              ld_hit;
  logic              push;
  logic              pop;
  logic [1:0]        fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2:0]        pending;
  logic [FW-1:0]     head;
  logic              ld_unused;

  assign ld_unused = ^bus.ld_addr[1:0];

  assign req_err = misaligned(bus.req_addr[1:0])
                || (|bus.req_addr[ADDR_W-1:IW+2]);
  assign ld_hit  = bus.ld_en
                && !(|bus.ld_addr[ADDR_W-1:IW+2]);

  assign pop     = bus.rsp_valid && bus.rsp_ready;
  // s1 holds a slot in the FIFO budget so a push never overflows
  assign pending = {1'b0, fifo_cnt}
                 + {2'b0, s1_valid}
                 - {2'b0, pop};

  assign bus.req_ready = !reset && !bus.flush
                      && !bus.ld_en && (pending < 3'd2);
  assign accept = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk) begin
    if (ld_hit)
      mem[bus.ld_addr[IW+1:2]] <= bus.ld_data;
    if (accept && !req_err)
      rd_data <= mem[bus.req_addr[IW+1:2]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_err  <= req_err;
        s1_addr <= bus.req_addr;
      end
    end
  end

  assign s1_insn = s1_err ? DATA_W'(INSN_NOP) : rd_data;
  assign push    = s1_valid && !bus.flush
                && (!fifo_full || pop);

  itcm_resp_fifo #(.W(FW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .din   ({s1_err, s1_addr, s1_insn}),
    .dout  (head),
    .cnt   (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign {bus.rsp_err, bus.rsp_addr, bus.rsp_insn} = head;

endmodule

// File: tb/tb_itcm_fetch_responder.sv
// Directed bench for itcm_fetch_responder: load, streaming,
// backpressure, error fetches, flush, load/fetch ordering, reset.
module tb_itcm_fetch_responder;
  import itcm_fetch_responder_pkg::*;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  logic [31:0] a_val [4];
  logic [31:0] b_val;
  logic [31:0] e_addr [2];

  itcm_fetch_responder_if bus ();

  itcm_fetch_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b1;
    tick();
    #1;
    vecs++;
    if (bus.req_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready: got %b, want 0", bus.req_ready);
    end
    vecs++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_valid_err: got %b%b, want 00",
               bus.rsp_valid, bus.rsp_err);
    end
    vecs++;
    if (bus.rsp_insn !== 32'h0 || bus.rsp_addr !== 32'h0) begin
      errs++;
      $display("FAIL reset_data: got %h/%h, want 0/0",
               bus.rsp_insn, bus.rsp_addr);
    end
    tick();
    reset = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    #1;
    vecs++;
    if (bus.rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL post_reset_valid: got %b, want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.ld_en   = 1'b1;
      bus.ld_addr = 32'(4 * i);
      bus.ld_data = a_val[i];
    end
    // word index 1024 must be dropped, not wrap onto word 0
    tick();
    bus.ld_addr = 32'h0000_1000;
    bus.ld_data = 32'hDEAD_BEEF;
    tick();
    bus.ld_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      bus.req_valid = (c < 4);
      bus.req_addr  = 32'(4 * c);
      #1;
      if (c < 4) begin
        vecs++;
        if (bus.req_ready !== 1'b1) begin
          errs++;
          $display("FAIL b2b_ready c%0d: got %b, want 1", c, bus.req_ready);
        end
      end
      vecs++;
      if (c >= 2 && c < 6) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0
            || bus.rsp_insn !== a_val[c-2]
            || bus.rsp_addr !== 32'(4 * (c - 2))) begin
          errs++;
          $display("FAIL b2b_rsp c%0d: got v%b %h@%h, want v1 %h@%h",
                   c, bus.rsp_valid, bus.rsp_insn, bus.rsp_addr,
                   a_val[c-2], 32'(4 * (c - 2)));
        end
      end else if (bus.rsp_valid !== 1'b0) begin
        errs++;
        $display("FAIL b2b_idle c%0d: got %b, want 0", c, bus.rsp_valid);
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int idx;
    int got;
    idx = 0;
    got = 0;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'(4 * idx);
      #1;
      vecs++;
      if (bus.req_ready !== (c < 2)) begin
        errs++;
        $display("FAIL bp_ready c%0d: got %b, want %b",
                 c, bus.req_ready, (c < 2));
      end
      if (bus.req_ready) idx++;
    end
    vecs++;
    if (idx !== 2) begin
      errs++;
      $display("FAIL bp_accepted: got %0d, want 2", idx);
    end
    vecs++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_insn !== a_val[0]) begin
      errs++;
      $display("FAIL bp_hold: got v%b %h, want v1 %h",
               bus.rsp_valid, bus.rsp_insn, a_val[0]);
    end
    for (int c = 0; c < 20 && (got < 4 || idx < 4); c++) begin
      tick();
      bus.req_valid = (idx < 4);
      bus.req_addr  = 32'(4 * idx);
      bus.rsp_ready = 1'b1;
      #1;
      if (bus.req_valid && bus.req_ready) idx++;
      if (bus.rsp_valid) begin
        vecs++;
        if (got >= 4) begin
          errs++;
          $display("FAIL bp_extra: got %h, want none", bus.rsp_insn);
        end else if (bus.rsp_insn !== a_val[got]
                     || bus.rsp_addr !== 32'(4 * got)) begin
          errs++;
          $display("FAIL bp_order %0d: got %h@%h, want %h@%h", got,
                   bus.rsp_insn, bus.rsp_addr, a_val[got], 32'(4 * got));
        end
        got++;
      end
    end
    vecs++;
    if (got !== 4 || idx !== 4) begin
      errs++;
      $display("FAIL bp_count: got %0d/%0d, want 4/4", got, idx);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.req_valid = 1'b0;
      #1;
      vecs++;
      if (bus.rsp_valid !== 1'b0) begin
        errs++;
        $display("FAIL bp_dup c%0d: got %b, want 0", c, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_err();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      bus.req_valid = (c < 2);
      bus.req_addr  = (c < 2) ? e_addr[c] : 32'h0;
      #1;
      vecs++;
      if (c == 2 || c == 3) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1
            || bus.rsp_insn !== 32'h0000_0013
            || bus.rsp_addr !== e_addr[c-2]) begin
          errs++;
          $display("FAIL err_rsp c%0d: got v%b e%b %h@%h, want v1 e1 %h@%h",
                   c, bus.rsp_valid, bus.rsp_err, bus.rsp_insn,
                   bus.rsp_addr, 32'h0000_0013, e_addr[c-2]);
        end
      end else if (bus.rsp_valid !== 1'b0) begin
        errs++;
        $display("FAIL err_idle c%0d: got %b, want 0", c, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_flush();
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'(4 * c);
      #1;
      vecs++;
      if (bus.req_ready !== 1'b1) begin
        errs++;
        $display("FAIL fl_fill c%0d: got %b, want 1", c, bus.req_ready);
      end
    end
    tick();
    bus.req_addr = 32'h8;
    bus.flush    = 1'b1;
    #1;
    vecs++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) begin
      errs++;
      $display("FAIL fl_cycle: got rdy%b v%b, want rdy0 v1",
               bus.req_ready, bus.rsp_valid);
    end
    tick();
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    vecs++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL fl_after: got v%b rdy%b, want v0 rdy1",
               bus.rsp_valid, bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    #1;
    vecs++;
    if (bus.rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL fl_gap: got %b, want 0", bus.rsp_valid);
    end
    tick();
    vecs++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_insn !== a_val[2]
        || bus.rsp_addr !== 32'h8) begin
      errs++;
      $display("FAIL fl_refetch: got v%b %h@%h, want v1 %h@8",
               bus.rsp_valid, bus.rsp_insn, bus.rsp_addr, a_val[2]);
    end
    tick();
    vecs++;
    if (bus.rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL fl_only: got %b, want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_load_fetch();
    bus.rsp_ready = 1'b1;
    tick();
    bus.ld_en     = 1'b1;
    bus.ld_addr   = 32'h4;
    bus.ld_data   = b_val;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h4;
    #1;
    vecs++;
    if (bus.req_ready !== 1'b0) begin
      errs++;
      $display("FAIL lf_block: got %b, want 0", bus.req_ready);
    end
    tick();
    bus.ld_en = 1'b0;
    #1;
    vecs++;
    if (bus.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL lf_accept: got %b, want 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    tick();
    vecs++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_insn !== b_val
        || bus.rsp_addr !== 32'h4) begin
      errs++;
      $display("FAIL lf_new: got v%b %h@%h, want v1 %h@4",
               bus.rsp_valid, bus.rsp_insn, bus.rsp_addr, b_val);
    end
    tick();
    bus.ld_en   = 1'b1;
    bus.ld_data = a_val[1];
    tick();
    bus.ld_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'(4 * c);
    end
    tick();
    bus.req_valid = 1'b0;
    #1;
    vecs++;
    if (bus.rsp_valid !== 1'b1) begin
      errs++;
      $display("FAIL rm_pre: got %b, want 1", bus.rsp_valid);
    end
    #1;
    reset = 1'b1;
    #1;
    vecs++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0
        || bus.rsp_err !== 1'b0 || bus.rsp_insn !== 32'h0
        || bus.rsp_addr !== 32'h0) begin
      errs++;
      $display("FAIL rm_clear: got v%b r%b e%b %h@%h, want all 0",
               bus.rsp_valid, bus.req_ready, bus.rsp_err,
               bus.rsp_insn, bus.rsp_addr);
    end
    tick();
    tick();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vecs++;
      if (bus.rsp_valid !== 1'b0) begin
        errs++;
        $display("FAIL rm_stale c%0d: got %b, want 0", c, bus.rsp_valid);
      end
    end
    test_back_to_back();
  endtask

  initial begin
    a_val[0] = 32'hA0A0_0000;
    a_val[1] = 32'hA1A1_0001;
    a_val[2] = 32'hA2A2_0002;
    a_val[3] = 32'hA3A3_0003;
    b_val    = 32'hBEEF_0001;
    e_addr[0] = 32'h0000_0006;
    e_addr[1] = 32'h0000_1000;
    vecs = 0;
    errs = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.ld_en     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    test_reset();
    test_load();
    test_back_to_back();
    test_backpressure();
    test_err();
    test_flush();
    test_load_fetch();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
